// File: rtl/mult_issue_ctrl_pkg.sv
// mult_issue_ctrl_pkg: shared widths, latency, status target and scoreboard entry type
package mult_issue_ctrl_pkg;
    localparam int LATENCY = 4;
    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam logic [REG_W-1:0] STATUS_REG = 5'd30;
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } sb_entry_t;
endpackage

// File: rtl/mult_issue_ctrl_if.sv
// mult_issue_ctrl_if: decode, multiplier, writeback and register-file signals of the issue controller
interface mult_issue_ctrl_if;
    import mult_issue_ctrl_pkg::*;
    logic              dec_valid, dec_is_mult, dec_stall, mult_signal;
    logic [REG_W-1:0]  dec_rd, dec_rs, dec_rt;
    logic              mult_rdy, mult_exc;
    logic [DATA_W-1:0] mult_result;
    logic              wb_valid, wb_stall;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              rf_we;
    logic [REG_W-1:0]  rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              proto_err;
    logic [15:0]       mult_cnt;
    modport master (
        output dec_valid, dec_is_mult, dec_rd, dec_rs, dec_rt, mult_rdy, mult_exc, mult_result,
               wb_valid, wb_rd, wb_data,
        input  dec_stall, mult_signal, wb_stall, rf_we, rf_addr, rf_data, proto_err, mult_cnt
    );
    modport slave (
        input  dec_valid, dec_is_mult, dec_rd, dec_rs, dec_rt, mult_rdy, mult_exc, mult_result,
               wb_valid, wb_rd, wb_data,
        output dec_stall, mult_signal, wb_stall, rf_we, rf_addr, rf_data, proto_err, mult_cnt
    );
endinterface

// File: rtl/mult_scoreboard.sv
// mult_scoreboard: in-flight destination shift register with a 3-port source/destination match
module mult_scoreboard
    import mult_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_i,
    input  logic [REG_W-1:0] dst_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    output logic             hazard_o,
    output sb_entry_t        done_o
);
    sb_entry_t [LATENCY-1:0] sb_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sb_q <= '0;
        else        sb_q <= {sb_q[LATENCY-2:0], sb_entry_t'{valid: issue_i, rd: dst_i}};
    // the completing slot still counts: a dependant may only issue the cycle after the result lands
    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < LATENCY; i++)
            hazard_o |= sb_q[i].valid && (sb_q[i].rd != '0) &&
                        (sb_q[i].rd == rs_i || sb_q[i].rd == rt_i || sb_q[i].rd == dst_i);
    end
    assign done_o = sb_q[LATENCY-1];
endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: mult issue/hazard control and register-file write-port arbitration
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    mult_issue_ctrl_if.slave bus
);
    logic       hazard, issue, comp;
    sb_entry_t  done;
    logic       proto_err_q, proto_err_d;
    logic [15:0] mult_cnt_q, mult_cnt_d;
    mult_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_i  (issue),
        .dst_i    (bus.dec_rd),
        .rs_i     (bus.dec_rs),
        .rt_i     (bus.dec_rt),
        .hazard_o (hazard),
        .done_o   (done)
    );
    assign issue           = bus.dec_valid & bus.dec_is_mult & ~hazard;
    assign comp            = done.valid;
    assign bus.dec_stall   = bus.dec_valid & hazard;
    assign bus.mult_signal = issue;
    assign bus.wb_stall    = bus.wb_valid & comp;
    assign bus.proto_err   = proto_err_q;
    assign bus.mult_cnt    = mult_cnt_q;
    // completion owns the port; an exception redirects the write to the status register
    always_comb begin
        bus.rf_we   = comp ? (bus.mult_exc | (done.rd != '0)) : bus.wb_valid;
        bus.rf_addr = !bus.rf_we ? '0 : !comp ? bus.wb_rd : bus.mult_exc ? STATUS_REG : done.rd;
        bus.rf_data = !bus.rf_we ? '0 : !comp ? bus.wb_data :
                      bus.mult_exc ? DATA_W'(1) : bus.mult_result;
        proto_err_d = proto_err_q | (comp & ~bus.mult_rdy);
        mult_cnt_d  = (issue && mult_cnt_q != 16'hFFFF) ? mult_cnt_q + 16'd1 : mult_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            proto_err_q <= 1'b0;
            mult_cnt_q  <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            mult_cnt_q  <= mult_cnt_d;
        end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed and random checks against a timestamped in-flight list model
module tb_mult_issue_ctrl;
    import mult_issue_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mult_issue_ctrl_if bus ();
    mult_issue_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct { logic [REG_W-1:0] rd; int t; } rec_t;
    rec_t q[$];
    int cyc = 0, m_cnt = 0, n_vec = 0, n_err = 0;
    bit m_perr = 0, last_wbs = 0;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h exp %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask
    task automatic drv(bit v, bit m, int rd, int rs, int rt, bit rdy, bit exc,
                       logic [31:0] res, bit wv, int wrd, logic [31:0] wd);
        bus.dec_valid = v; bus.dec_is_mult = m;
        bus.dec_rd = REG_W'(rd); bus.dec_rs = REG_W'(rs); bus.dec_rt = REG_W'(rt);
        bus.mult_rdy = rdy; bus.mult_exc = exc; bus.mult_result = res;
        bus.wb_valid = wv; bus.wb_rd = REG_W'(wrd); bus.wb_data = wd;
    endtask
    task automatic idle();
        drv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask
    // in flight = issued within the last LATENCY cycles; the oldest of those is completing now
    task automatic cycle();
        bit haz, comp, iss, we;
        logic [REG_W-1:0] crd, ea;
        logic [31:0] ed;
        @(negedge clk);
        haz = 0; comp = 0; crd = '0;
        foreach (q[i]) begin
            if (q[i].rd != 0 && (q[i].rd == bus.dec_rs || q[i].rd == bus.dec_rt || q[i].rd == bus.dec_rd))
                haz = 1;
            if (q[i].t == cyc - LATENCY) begin comp = 1; crd = q[i].rd; end
        end
        iss = bus.dec_valid && bus.dec_is_mult && !haz;
        if (comp) begin
            we = bus.mult_exc || crd != 0;
            ea = !we ? 5'd0 : bus.mult_exc ? 5'd30 : crd;
            ed = !we ? 32'd0 : bus.mult_exc ? 32'd1 : bus.mult_result;
        end else begin
            we = bus.wb_valid;
            ea = we ? bus.wb_rd : 5'd0;
            ed = we ? bus.wb_data : 32'd0;
        end
        chk("dec_stall", 32'(bus.dec_stall), 32'(bus.dec_valid && haz));
        chk("mult_signal", 32'(bus.mult_signal), 32'(iss));
        chk("wb_stall", 32'(bus.wb_stall), 32'(bus.wb_valid && comp));
        chk("rf_we", 32'(bus.rf_we), 32'(we));
        chk("rf_addr", 32'(bus.rf_addr), 32'(ea));
        chk("rf_data", bus.rf_data, ed);
        chk("proto_err", 32'(bus.proto_err), 32'(m_perr));
        chk("mult_cnt", 32'(bus.mult_cnt), 32'(m_cnt));
        last_wbs = bus.wb_valid && comp;
        if (rst_n) begin
            if (iss) q.push_back('{bus.dec_rd, cyc});
            if (comp && !bus.mult_rdy) m_perr = 1;
            if (iss && m_cnt < 65535) m_cnt++;
        end
        q = q.find(x) with (x.t > cyc - LATENCY);
        cyc++;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        q.delete(); m_cnt = 0; m_perr = 0;
        idle();
        cycle();
        rst_n = 1'b1;
    endtask
    initial begin
        logic [REG_W-1:0] wrd;
        logic [31:0] wd;
        idle();
        #1;
        do_reset();
        // RAW: add r4,r3,r5 waits behind mult r3
        drv(1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        drv(1, 0, 4, 3, 5, 1, 0, 32'h15, 0, 0, 0);
        repeat (5) cycle();
        idle(); repeat (2) cycle();
        // plain completion, exception completion, then wb collision
        drv(1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        idle(); repeat (3) cycle();
        drv(0, 0, 0, 0, 0, 1, 0, 32'h15, 0, 0, 0); cycle();
        drv(1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        idle(); repeat (3) cycle();
        drv(0, 0, 0, 0, 0, 1, 1, 32'hDEAD, 0, 0, 0); cycle();
        drv(1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        idle(); repeat (3) cycle();
        drv(0, 0, 0, 0, 0, 1, 0, 32'h77, 1, 7, 32'hCAFE); cycle();
        drv(0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 7, 32'hCAFE); cycle();
        idle(); cycle();
        // four independent mults back to back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 10 + i, 20 + i, 24 + i, 1, 0, 32'h100 + i, 0, 0, 0);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 0, 1, 0, 32'h200 + i, 1, 9, 32'h55);
            cycle();
        end
        chk("cnt_after_4", 32'(bus.mult_cnt), 32'd4);
        idle(); cycle();
        // reset mid-flight drops the pending result
        drv(1, 1, 3, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        idle(); cycle();
        do_reset();
        drv(0, 0, 0, 0, 0, 1, 0, 32'h99, 0, 0, 0); repeat (3) cycle();
        chk("late_rf_we", 32'(bus.rf_we), 32'd0);
        chk("late_proto", 32'(bus.proto_err), 32'd0);
        // random traffic
        do_reset();
        wrd = '0; wd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!last_wbs) begin wrd = REG_W'($urandom); wd = $urandom; end
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 199) != 0,
                $urandom_range(0, 4) == 0, $urandom, last_wbs || $urandom_range(0, 1) == 1, wrd, wd);
            cycle();
        end
        // missing mult_rdy at completion latches proto_err
        do_reset();
        drv(1, 1, 6, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        idle(); repeat (3) cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 32'h5, 0, 0, 0); cycle();
        idle(); repeat (2) cycle();
        chk("proto_sticky", 32'(bus.proto_err), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
